// File: rtl/bus_xcvr_sync_if.sv
// ---------------------------------------------------------------------------
// bus_xcvr_sync_if
// Purpose : Bundles the local-side data, control and status signals of the
//           bus_xcvr_sync transceiver. The shared tri-state bus itself
//           (d_bus) is kept as a plain inout on the module so that
//           tri-state resolution stays on an ordinary net.
// Signals : d_in        local data to drive onto d_bus
//           d_out       data captured from d_bus
//           cs_n, dce   chip select (active-low) and direction (1 = RX)
//           bus_oe      high while the transceiver drives d_bus
//           d_out_valid d_out holds a sample captured in the previous cycle
//           busy        high during the turnaround dead period
//           clr_count, tx_count, rx_count   only with XFER_COUNT_EN defined
// Modports: slave  - the transceiver side
//           master - the controller / testbench side
// Macro   : XFER_COUNT_EN adds the transfer counters.
// ---------------------------------------------------------------------------
interface bus_xcvr_sync_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic             cs_n;
    logic             dce;
    logic             bus_oe;
    logic             d_out_valid;
    logic             busy;
`ifdef XFER_COUNT_EN
    logic             clr_count;
    logic [15:0]      tx_count;
    logic [15:0]      rx_count;

    modport slave (
        input  d_in, cs_n, dce, clr_count,
        output d_out, bus_oe, d_out_valid, busy, tx_count, rx_count
    );
    modport master (
        output d_in, cs_n, dce, clr_count,
        input  d_out, bus_oe, d_out_valid, busy, tx_count, rx_count
    );
`else
    modport slave (
        input  d_in, cs_n, dce,
        output d_out, bus_oe, d_out_valid, busy
    );
    modport master (
        output d_in, cs_n, dce,
        input  d_out, bus_oe, d_out_valid, busy
    );
`endif
endinterface

// File: rtl/bus_xcvr_sync.sv
// ---------------------------------------------------------------------------
// bus_xcvr_sync
// Purpose : Clocked bidirectional bus transceiver (IC82x6 successor). Moves
//           data between the local pair d_in/d_out and the shared tri-state
//           bus d_bus. A turnaround state inserts TURNAROUND dead cycles on
//           every direction change so this block and an external driver are
//           never both on the bus.
// Params  : WIDTH (1..32), TURNAROUND (1..15), INVERT (0 = 8216, 1 = 8226)
// Ports   : clk    system clock, rising edge
//           rst    synchronous reset, active-high
//           bus    bus_xcvr_sync_if.slave (d_in, d_out, cs_n, dce, bus_oe,
//                  d_out_valid, busy, optional counters)
//           d_bus  shared tri-state bus
// Macro   : XFER_COUNT_EN adds tx_count/rx_count (saturating 16-bit) and the
//           clr_count input; without it the block has no counters.
// ---------------------------------------------------------------------------
module bus_xcvr_sync #(
    parameter int WIDTH      = 8,
    parameter int TURNAROUND = 1,
    parameter int INVERT     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_xcvr_sync_if.slave       bus,
    inout  wire  [WIDTH-1:0]     d_bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_RX   = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    localparam logic [3:0]       TCNT_INIT = 4'(TURNAROUND - 1);
    localparam logic [WIDTH-1:0] INV_MASK  = (INVERT != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    state_t           state_q, state_d;
    state_t           tgt_q, tgt_d;
    state_t           req;
    logic [3:0]       tcnt_q, tcnt_d;
    logic             bus_oe_q;
    logic [WIDTH-1:0] d_in_q;
    logic [WIDTH-1:0] d_out_q;
    logic             d_out_valid_q;

    // Request decode; TURN is never a request, so it doubles as "no target".
    always_comb begin
        req = ST_IDLE;
        if (!bus.cs_n) begin
            req = bus.dce ? ST_RX : ST_TX;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                state_d = req;
            end
            ST_TX: begin
                if (req != ST_TX) begin
                    state_d = ST_TURN;
                    tgt_d   = req;
                    tcnt_d  = TCNT_INIT;
                end
            end
            ST_RX: begin
                if (req == ST_IDLE) begin
                    state_d = ST_IDLE;
                end else if (req == ST_TX) begin
                    state_d = ST_TURN;
                    tgt_d   = ST_TX;
                    tcnt_d  = TCNT_INIT;
                end
            end
            default: begin  // ST_TURN
                // Target follows the request, but the dead-cycle count is
                // never restarted, so a change of mind cannot shorten or
                // lengthen the turnaround.
                tgt_d = req;
                if (tcnt_q == 4'd0) begin
                    state_d = tgt_q;
                end else begin
                    tcnt_d = tcnt_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tgt_q         <= ST_IDLE;
            tcnt_q        <= 4'd0;
            bus_oe_q      <= 1'b0;
            d_in_q        <= '0;
            d_out_q       <= '0;
            d_out_valid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            tcnt_q   <= tcnt_d;
            // Enable follows the next state so the bus is released on the
            // very edge that leaves TX.
            bus_oe_q <= (state_d == ST_TX);
            if (state_d == ST_TX) begin
                d_in_q <= bus.d_in;
            end
            // Capture on every edge that lands in (or stays in) RX; the
            // edge leaving RX does not capture, so d_out holds and valid drops.
            if (state_d == ST_RX) begin
                d_out_q       <= d_bus ^ INV_MASK;
                d_out_valid_q <= 1'b1;
            end else begin
                d_out_valid_q <= 1'b0;
            end
        end
    end

    assign d_bus           = bus_oe_q ? (d_in_q ^ INV_MASK) : {WIDTH{1'bz}};
    assign bus.bus_oe      = bus_oe_q;
    assign bus.d_out       = d_out_q;
    assign bus.d_out_valid = d_out_valid_q;
    assign bus.busy        = (state_q == ST_TURN);

`ifdef XFER_COUNT_EN
    logic [15:0] tx_count_q, rx_count_q;

    always_ff @(posedge clk) begin
        if (rst || bus.clr_count) begin
            tx_count_q <= 16'd0;
            rx_count_q <= 16'd0;
        end else begin
            if ((state_q == ST_TX) && (tx_count_q != 16'hFFFF)) begin
                tx_count_q <= tx_count_q + 16'd1;
            end
            if ((state_q == ST_RX) && (rx_count_q != 16'hFFFF)) begin
                rx_count_q <= rx_count_q + 16'd1;
            end
        end
    end

    assign bus.tx_count = tx_count_q;
    assign bus.rx_count = rx_count_q;
`endif
endmodule

// File: tb/tb_bus_xcvr_sync.sv
// ---------------------------------------------------------------------------
// tb_bus_xcvr_sync
// Directed bench for bus_xcvr_sync. Instance u0: WIDTH=8, TURNAROUND=3,
// INVERT=0. Instance u1: WIDTH=8, TURNAROUND=1, INVERT=1. Each shared bus
// also has a bench-side external driver. Inputs change and outputs are
// sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_bus_xcvr_sync;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bus_xcvr_sync_if #(.WIDTH(8)) if0 ();
    bus_xcvr_sync_if #(.WIDTH(8)) if1 ();

    wire  [7:0] d_bus0;
    wire  [7:0] d_bus1;
    logic       ext0_en, ext1_en;
    logic [7:0] ext0_val, ext1_val;

    assign d_bus0 = ext0_en ? ext0_val : 8'hzz;
    assign d_bus1 = ext1_en ? ext1_val : 8'hzz;

    bus_xcvr_sync #(.WIDTH(8), .TURNAROUND(3), .INVERT(0)) u0 (
        .clk   (clk),
        .rst   (rst),
        .bus   (if0.slave),
        .d_bus (d_bus0)
    );

    bus_xcvr_sync #(.WIDTH(8), .TURNAROUND(1), .INVERT(1)) u1 (
        .clk   (clk),
        .rst   (rst),
        .bus   (if1.slave),
        .d_bus (d_bus1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, expv);
    endtask

    initial begin
        rst = 1'b1;
        if0.cs_n = 1'b0; if0.dce = 1'b0; if0.d_in = 8'hA5;
        if1.cs_n = 1'b1; if1.dce = 1'b0; if1.d_in = 8'h00;
`ifdef XFER_COUNT_EN
        if0.clr_count = 1'b0;
        if1.clr_count = 1'b0;
`endif
        ext0_en = 1'b0; ext0_val = 8'h00;
        ext1_en = 1'b0; ext1_val = 8'h00;

        // Reset held 2 cycles with a TX request pending.
        tick();
        tick();
        chk("rst_oe",    32'(if0.bus_oe), 32'd0);
        chk("rst_dout",  32'(if0.d_out), 32'h00);
        chk("rst_valid", 32'(if0.d_out_valid), 32'd0);
        chk("rst_busy",  32'(if0.busy), 32'd0);
`ifdef XFER_COUNT_EN
        chk("rst_txcnt", 32'(if0.tx_count), 32'd0);
`endif

        // First drive one edge after reset drops.
        rst = 1'b0;
        tick();
        chk("tx_oe",     32'(if0.bus_oe), 32'd1);
        chk("tx_a5",     32'(d_bus0), 32'hA5);
        if0.d_in = 8'h3C;
        tick();
        chk("tx_3c",     32'(d_bus0), 32'h3C);

        // TX -> RX: bus released at once, exactly 3 busy cycles.
        if0.dce = 1'b1;
        tick();
        chk("t2r_oe",    32'(if0.bus_oe), 32'd0);
        chk("t2r_busy1", 32'(if0.busy), 32'd1);
        tick();
        chk("t2r_busy2", 32'(if0.busy), 32'd1);
        chk("t2r_oe2",   32'(if0.bus_oe), 32'd0);
        tick();
        chk("t2r_busy3", 32'(if0.busy), 32'd1);
        tick();
        chk("t2r_done",  32'(if0.busy), 32'd0);
        chk("t2r_oe4",   32'(if0.bus_oe), 32'd0);

        // RX capture with external driver switched on after busy drops.
        ext0_en = 1'b1; ext0_val = 8'h81;
        tick();
        chk("rx_81",     32'(if0.d_out), 32'h81);
        chk("rx_valid",  32'(if0.d_out_valid), 32'd1);
        chk("rx_oe",     32'(if0.bus_oe), 32'd0);
        ext0_val = 8'h42;
        tick();
        chk("rx_42",     32'(if0.d_out), 32'h42);

        // RX -> TX: same 3 dead cycles, d_out holds, valid drops.
        if0.dce = 1'b0; if0.d_in = 8'h5A; ext0_en = 1'b0;
        tick();
        chk("r2t_busy1", 32'(if0.busy), 32'd1);
        chk("r2t_valid", 32'(if0.d_out_valid), 32'd0);
        chk("r2t_hold",  32'(if0.d_out), 32'h42);
        tick();
        chk("r2t_busy2", 32'(if0.busy), 32'd1);
        tick();
        chk("r2t_busy3", 32'(if0.busy), 32'd1);
        chk("r2t_oe3",   32'(if0.bus_oe), 32'd0);
        tick();
        chk("r2t_busy4", 32'(if0.busy), 32'd0);
        chk("r2t_oe4",   32'(if0.bus_oe), 32'd1);
        chk("r2t_5a",    32'(d_bus0), 32'h5A);

        // Back to RX, then cs_n=1 goes straight to IDLE.
        if0.dce = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("rx2_busy",  32'(if0.busy), 32'd0);
        ext0_en = 1'b1; ext0_val = 8'h99;
        tick();
        chk("rx2_99",    32'(if0.d_out), 32'h99);
        if0.cs_n = 1'b1;
        tick();
        chk("idle_busy", 32'(if0.busy), 32'd0);
        chk("idle_valid",32'(if0.d_out_valid), 32'd0);
        chk("idle_hold", 32'(if0.d_out), 32'h99);
        chk("idle_oe",   32'(if0.bus_oe), 32'd0);
        ext0_en = 1'b0;
        if0.cs_n = 1'b0; if0.dce = 1'b0;
        tick();
        chk("idle_tx_oe",32'(if0.bus_oe), 32'd1);

        // Reset while in TURN at tcnt=1.
        if0.dce = 1'b1;
        tick();
        tick();
        chk("mid_busy",  32'(if0.busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("mrst_busy", 32'(if0.busy), 32'd0);
        chk("mrst_oe",   32'(if0.bus_oe), 32'd0);
        chk("mrst_dout", 32'(if0.d_out), 32'h00);
        rst = 1'b0;
        if0.cs_n = 1'b1;
        tick();
        chk("post_busy", 32'(if0.busy), 32'd0);

        // Inverting instance: RX 81 -> 7E, TX A5 -> 5A, one dead cycle.
        if1.cs_n = 1'b0; if1.dce = 1'b1;
        ext1_en = 1'b1; ext1_val = 8'h81;
        tick();
        chk("inv_rx_7e", 32'(if1.d_out), 32'h7E);
        chk("inv_valid", 32'(if1.d_out_valid), 32'd1);
        if1.dce = 1'b0; if1.d_in = 8'hA5; ext1_en = 1'b0;
        tick();
        chk("inv_busy",  32'(if1.busy), 32'd1);
        chk("inv_oe0",   32'(if1.bus_oe), 32'd0);
        tick();
        chk("inv_busy0", 32'(if1.busy), 32'd0);
        chk("inv_oe1",   32'(if1.bus_oe), 32'd1);
        chk("inv_tx_5a", 32'(d_bus1), 32'h5A);
        if1.cs_n = 1'b1;

`ifdef XFER_COUNT_EN
        // Saturation and clear of the TX counter.
        if0.cs_n = 1'b0; if0.dce = 1'b0;
        if0.clr_count = 1'b1;
        tick();
        if0.clr_count = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            tick();
        end
        chk("txcnt_sat", 32'(if0.tx_count), 32'hFFFF);
        chk("rxcnt_zero",32'(if0.rx_count), 32'h0000);
        if0.clr_count = 1'b1;
        tick();
        chk("txcnt_clr", 32'(if0.tx_count), 32'h0000);
        if0.clr_count = 1'b0;
        if0.cs_n = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bus_xcvr_sync.md
Name: bus_xcvr_sync

Overview:
- Clocked, parametrised successor to the IC82x6 (8216/8226) bidirectional bus driver.
- Moves data between a unidirectional local pair (d_in/d_out) and a shared tri-state bus (d_bus) under cs_n/dce control. Intended for the ISA-CAMAC interface data path.
- Adds registered I/O, a configurable optional inversion (8226 mode) and a turnaround state machine. The turnaround guarantees a dead period between driving and releasing d_bus, so direction changes never cause bus contention.

Parameters:
- WIDTH, 8, data width of d_in, d_out and d_bus (1..32).
- TURNAROUND, 1, dead cycles inserted on every drive-to-receive or receive-to-drive change (1..15).
- INVERT, 0, 0 = non-inverting (8216 mode); 1 = data inverted in both directions (8226 mode).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- d_in  input  WIDTH  local data to be driven onto d_bus
- d_out  output  WIDTH  registered data captured from d_bus
- d_bus  inout  WIDTH  shared tri-state bus
- cs_n  input  1  chip select, active-low
- dce  input  1  direction: 0 = drive d_bus from d_in (TX), 1 = capture d_bus into d_out (RX)
- bus_oe  output  1  registered; high while this block drives d_bus
- d_out_valid  output  1  registered; high when d_out holds a sample captured in the previous cycle
- busy  output  1  high while in TURN

Behaviour:
- Request decode, sampled at each rising edge:
  - cs_n=1 -> IDLE request
  - cs_n=0, dce=0 -> TX request
  - cs_n=0, dce=1 -> RX request
- States: IDLE, TX, RX, TURN. TURN has a 4-bit down-counter tcnt and a 2-bit target tgt.
- Reset state: IDLE, bus_oe=0 (d_bus all Z), d_out=0, d_out_valid=0, busy=0, tcnt=0.
- Reset asserted mid-operation wins over everything. The bus is released at the same edge and no turnaround is inserted.
- From IDLE:
  - TX request -> TX.
  - RX request -> RX.
  - Otherwise stay in IDLE.
- From TX:
  - TX request -> stay in TX.
  - Any other request -> TURN, with tgt set to the request and tcnt=TURNAROUND-1.
  - bus_oe goes low at that same edge.
- From RX:
  - RX request -> stay in RX.
  - IDLE request -> IDLE directly.
  - TX request -> TURN with tgt=TX.
- In TURN:
  - bus_oe=0 and busy=1.
  - Each cycle tcnt is decremented. When tcnt==0, move to tgt at the next edge.
  - The request is re-sampled every TURN cycle. If it changes, tgt is updated but tcnt is not restarted.
  - If tgt becomes RX after leaving TX, the remaining dead cycles still elapse.
- TX datapath:
  - A d_in register is loaded every cycle in which the next state is TX.
  - d_bus = bus_oe ? (INVERT ? ~d_in_reg : d_in_reg) : Z.
  - Latency: d_in sampled at edge N appears on d_bus after edge N.
  - First drive after IDLE: bus_oe rises one edge after cs_n=0,dce=0 is sampled.
- RX datapath:
  - In RX, at every edge, d_out <= INVERT ? ~d_bus : d_bus and d_out_valid <= 1.
  - In every other state, d_out holds its last value and d_out_valid <= 0.
  - d_out is never tri-stated.
- Contention rule: bus_oe is never 1 in any cycle adjacent to an RX cycle. A TX-to-RX transition gives at least TURNAROUND cycles with bus_oe=0.
- Glitches on cs_n/dce shorter than one clock that are not sampled have no effect. Inputs are assumed synchronous to clk; no synchronisers are included.

Optional Feature:
- Macro XFER_COUNT_EN.
- When defined, two extra outputs are added: tx_count[15:0] and rx_count[15:0].
  - tx_count increments on each cycle in TX state; rx_count increments on each cycle in RX state.
  - Both saturate at 16'hFFFF and reset to 0.
  - Input clr_count (1 bit) zeroes both counters at the next edge and takes priority over increment.
- When undefined, these ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with cs_n=0, dce=0 -> bus_oe=0, d_bus=ZZ, d_out=00, d_out_valid=0; bus_oe=1 one edge after rst drops.
- TX, WIDTH=8, INVERT=0: d_in=8'hA5, cs_n=0, dce=0 -> d_bus=A5 after the first edge. Then with d_in=3C, d_bus=3C one edge later.
- RX: cs_n=0, dce=1, external bus drives 8'h81 -> d_out=81, d_out_valid=1 after the first edge, bus_oe=0 throughout. Repeat with INVERT=1 -> d_out=7E.
- TX->RX turnaround, TURNAROUND=3: switch dce 0->1 while in TX -> bus_oe falls at the first edge, busy=1 for exactly 3 cycles, then RX.
  - External driver enabled only after busy=0 shows no X on d_bus.
  - RX->TX gives the same 3 dead cycles.
- cs_n=1 in RX -> IDLE at the next edge with no busy cycle. d_out holds its last value and d_out_valid=0.
- Reset mid-TURN with rst=1 at tcnt=1 -> IDLE, busy=0. With XFER_COUNT_EN: 70000 TX cycles -> tx_count=FFFF; clr_count=1 -> 0000 next edge.
